rng_coeff_sampler: RTL
======================

RNG_COEFF_SAMPLER -- requirements
Module: rng_coeff_sampler

Interface
REQ-001 SHALL have parameters: NUM_BITS, default 32, RNG word width; COEF_BITS, default 8, uniform coefficient width; N_COEF, default 256, coefficients per polynomial.
REQ-002 SHALL accept only parameter sets where NUM_BITS is a multiple of COEF_BITS and N_COEF is a power of two of at least 2.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 resetn  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle request to sample one polynomial; honoured only in IDLE.
REQ-006 mode  in  1  0 = binary coefficients {0,1}; 1 = uniform COEF_BITS-bit coefficients; sampled with start.
REQ-007 busy  out  1  high in every state except IDLE.
REQ-008 done  out  1  one-cycle pulse after the last coefficient is accepted.
REQ-009 rng_re  out  1  read request to the upstream simplerng (drives its dat_re).
REQ-010 rng_do  in  NUM_BITS  random word from simplerng.
REQ-011 rng_wait  in  1  simplerng not ready; rng_do is invalid while high.
REQ-012 coef_valid  out  1  coef_data/coef_idx valid.
REQ-013 coef_ready  in  1  downstream accepts; transfer = coef_valid & coef_ready on a rising edge.
REQ-014 coef_data  out  COEF_BITS  coefficient; binary mode zero-extended to COEF_BITS.
REQ-015 coef_idx  out  log2(N_COEF)  index of the current coefficient, 0..N_COEF-1.

Function
REQ-016 SHALL implement FSM states IDLE, FETCH, EMIT, FINISH.
REQ-017 IDLE: start=1 -> FETCH; mode latched, coefficient counter cleared to 0.
REQ-018 FETCH: rng_re=1; on an edge with rng_wait=0, rng_do SHALL be captured into the shift register, slice counter cleared, -> EMIT.
REQ-019 FETCH: rng_re SHALL stay high for as long as rng_wait=1; rng_do SHALL not be captured during those cycles.
REQ-020 EMIT: coef_valid=1; coef_data = shift register bit 0 (mode 0) or bits [COEF_BITS-1:0] (mode 1), LSB-first slicing.
REQ-021 EMIT: coef_data and coef_idx SHALL hold stable while coef_valid=1 and coef_ready=0.
REQ-022 On transfer, SHALL shift right by 1 (mode 0) or by COEF_BITS (mode 1) and increment both the coefficient and slice counters.
REQ-023 On transfer of coef_idx=N_COEF-1 -> FINISH; unused word bits SHALL be discarded.
REQ-024 On transfer that exhausts the word (NUM_BITS or NUM_BITS/COEF_BITS slices used) and coef_idx<N_COEF-1 -> FETCH.
REQ-025 FINISH: done=1 for exactly one cycle, -> IDLE.
REQ-026 start SHALL be ignored in FETCH, EMIT and FINISH; mode changes after start SHALL have no effect.
REQ-027 rng_re and coef_valid SHALL never be high in the same cycle.
REQ-028 Latency: first coef_valid SHALL rise on the cycle after the rng_wait=0 capture edge; zero bubble between slices of one word when coef_ready=1.
REQ-029 The coefficient counter SHALL wrap to 0 only by a new start, never by overflow.

Reset
REQ-030 resetn=0 SHALL immediately force IDLE, busy=0, done=0, rng_re=0, coef_valid=0, coef_data=0, coef_idx=0, shift register and counters 0.
REQ-031 Reset asserted mid-operation SHALL abort the polynomial; after release, nothing is emitted until a new start.
REQ-032 Release of resetn SHALL take effect on the next rising edge; a start coincident with the release edge is ignored.

Verification (N_COEF=8, COEF_BITS=8, NUM_BITS=32, coef_ready=1 unless stated)
REQ-033 Binary: start, mode=0, rng_do=0x0000_00A5 -> coef_data 1,0,1,0,0,1,0,1 with idx 0..7 on consecutive cycles; exactly one rng_re fetch; done pulse one cycle after idx 7; busy low after.
REQ-034 Uniform: mode=1, words 0x4433_2211 then 0x8877_6655 -> coef_data 0x11,0x22,...,0x88 with idx 0..7; exactly two fetches; rng_re high only between idx 3 and idx 4.
REQ-035 Upstream stall: rng_wait=1 for 5 cycles in FETCH -> rng_re high all 5 cycles plus the capture cycle; coef_valid low; captured word is the one present when rng_wait falls.
REQ-036 Backpressure: coef_ready=0 for 3 cycles at idx 2 -> coef_data/coef_idx hold; transfer resumes at idx 2; no coefficient lost or duplicated.
REQ-037 Reset mid-run: resetn=0 at idx 4 -> all outputs 0 within the reset cycle; after release, no coef_valid and no done until a new start.
REQ-038 Start while busy: start pulse at idx 3 with mode flipped -> ignored; sequence completes in the original mode; single done pulse.

Source files
------------

// File: rtl/rng_coeff_sampler.sv
// Samples one polynomial of N_COEF coefficients from an upstream simplerng word stream.
// Words are sliced LSB-first into binary (mode 0) or COEF_BITS-wide uniform (mode 1) coefficients.
module rng_coeff_sampler #(
    parameter int NUM_BITS  = 32,
    parameter int COEF_BITS = 8,
    parameter int N_COEF    = 256
) (
    input  logic                       i_clk,
    input  logic                       i_resetn,
    input  logic                       i_start,
    input  logic                       i_mode,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_rng_re,
    input  logic [NUM_BITS-1:0]        i_rng_do,
    input  logic                       i_rng_wait,
    output logic                       o_coef_valid,
    input  logic                       i_coef_ready,
    output logic [COEF_BITS-1:0]       o_coef_data,
    output logic [$clog2(N_COEF)-1:0]  o_coef_idx
);

    localparam int IDX_W       = $clog2(N_COEF);
    localparam int SLICE_W     = $clog2(NUM_BITS + 1);
    localparam int WORD_SLICES = NUM_BITS / COEF_BITS;

    generate
        if ((NUM_BITS % COEF_BITS) != 0 || N_COEF < 2 || (N_COEF & (N_COEF - 1)) != 0) begin : g_bad_params
            $error("rng_coeff_sampler: NUM_BITS must be a multiple of COEF_BITS and N_COEF a power of two >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EMIT,
        S_FINISH
    } state_t;

    state_t                 r_state;
    logic                   r_mode;
    logic [NUM_BITS-1:0]    r_shift;
    logic [SLICE_W-1:0]     r_slice;
    logic [IDX_W-1:0]       r_idx;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_rng_re;
    logic                   r_coef_valid;

    logic                   w_transfer;
    logic                   w_last_slice;
    logic                   w_last_coef;

    assign w_transfer   = r_coef_valid & i_coef_ready;
    assign w_last_slice = r_mode ? (r_slice == SLICE_W'(WORD_SLICES - 1))
                                 : (r_slice == SLICE_W'(NUM_BITS - 1));
    assign w_last_coef  = (r_idx == IDX_W'(N_COEF - 1));

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state      <= S_IDLE;
            r_mode       <= 1'b0;
            r_shift      <= '0;
            r_slice      <= '0;
            r_idx        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_rng_re     <= 1'b0;
            r_coef_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_state  <= S_FETCH;
                        r_mode   <= i_mode;
                        r_idx    <= '0;
                        r_busy   <= 1'b1;
                        r_rng_re <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (!i_rng_wait) begin
                        r_shift      <= i_rng_do;
                        r_slice      <= '0;
                        r_state      <= S_EMIT;
                        r_rng_re     <= 1'b0;
                        r_coef_valid <= 1'b1;
                    end
                end
                S_EMIT: begin
                    if (w_transfer) begin
                        r_shift <= r_mode ? (r_shift >> COEF_BITS) : (r_shift >> 1);
                        r_slice <= r_slice + SLICE_W'(1);
                        // The index saturates at the last coefficient; only a new start clears it.
                        if (w_last_coef) begin
                            r_shift      <= '0;
                            r_state      <= S_FINISH;
                            r_coef_valid <= 1'b0;
                            r_done       <= 1'b1;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                            if (w_last_slice) begin
                                r_state      <= S_FETCH;
                                r_coef_valid <= 1'b0;
                                r_rng_re     <= 1'b1;
                            end
                        end
                    end
                end
                S_FINISH: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_busy       <= 1'b0;
                    r_done       <= 1'b0;
                    r_rng_re     <= 1'b0;
                    r_coef_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_rng_re     = r_rng_re;
    assign o_coef_valid = r_coef_valid;
    assign o_coef_idx   = r_idx;
    assign o_coef_data  = r_mode ? r_shift[COEF_BITS-1:0] : COEF_BITS'(r_shift[0]);

endmodule
